mem_port_arbiter: RTL and testbench

//  Shares the single-port word Memory between the instruction-fetch stage (read-only port I)
//  and the MEM stage (read/write port D) of the 5-stage pipeline. Accepts one request per

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_starve_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating count of D wins while fetch waits
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_W)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port word memory between fetch (I) and MEM (D)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        err_addr
);

  state_e      state_q, state_d;
  owner_e      own_q, own_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic        err_q, err_d;

  logic        starve_at_limit;
  logic        any_gnt;
  logic [31:0] gnt_addr;
  logic        read_cycle;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock    (clock),
    .reset    (reset),
    .inc      (d_gnt && i_req),
    .clear    (i_gnt || !i_req),
    .at_limit (starve_at_limit)
  );

  // D wins unless fetch has been waiting through STARVE_LIMIT straight D grants.
  always_comb begin
    d_gnt    = d_req && !(i_req && starve_at_limit);
    i_gnt    = i_req && !d_gnt;
    any_gnt  = d_gnt || i_gnt;
    gnt_addr = d_gnt ? d_addr : i_addr;
  end

  always_comb begin
    state_d = any_gnt ? ST_ACCESS : ST_IDLE;
    own_d   = own_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (d_gnt) begin
      own_d   = OWN_D;
      we_d    = d_we;
      addr_d  = d_addr;
      wdata_d = d_wdata;
    end else if (i_gnt) begin
      own_d   = OWN_I;
      we_d    = 1'b0;
      addr_d  = i_addr;
    end

    // Memory output is only meaningful during a read ACCESS cycle; sample it at its end.
    read_cycle = (state_q == ST_ACCESS) && !we_q;
    i_rvalid_d = read_cycle && (own_q == OWN_I);
    d_rvalid_d = read_cycle && (own_q == OWN_D);
    i_rdata_d  = i_rvalid_d ? mem_dout : i_rdata_q;
    d_rdata_d  = d_rvalid_d ? mem_dout : d_rdata_q;

    err_d = err_q || (any_gnt && ((gnt_addr >> ADDR_W) != 32'd0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      own_q      <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      err_q      <= err_d;
    end
  end

  // Enables decode straight from state so an async reset kills a pending write at once.
  assign mem_ren  = (state_q == ST_ACCESS) && !we_q;
  assign mem_wen  = (state_q == ST_ACCESS) && we_q;
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign i_rdata  = i_rdata_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign err_addr = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a negedge-write memory
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        err_addr;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_t;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  resp_t exp_i[$], exp_d[$], obs_i[$], obs_d[$];
  string glog;
  int    cyc;
  int    overlap;
  int    total;
  int    bad;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .STARVE_LIMIT (4),
    .ADDR_W       (10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rdata  (i_rdata),
    .i_rvalid (i_rvalid),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rdata  (d_rdata),
    .d_rvalid (d_rvalid),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .err_addr (err_addr)
  );

  assign mem_dout = mem[mem_addr[9:0]];
  always @(negedge clock) if (mem_wen) mem[mem_addr[9:0]] = mem_din;

  // One clock: record grants and predict responses at negedge, record responses after posedge.
  task automatic step();
    @(negedge clock);
    if (mem_ren && mem_wen) overlap++;
    if (d_gnt && i_gnt) glog = {glog, "B"};
    else if (d_gnt) glog = {glog, "D"};
    else if (i_gnt) glog = {glog, "I"};
    if (d_gnt) begin
      if (d_we) ref_mem[d_addr[9:0]] = d_wdata;
      else exp_d.push_back('{ref_mem[d_addr[9:0]], cyc + 2});
    end
    if (i_gnt) exp_i.push_back('{ref_mem[i_addr[9:0]], cyc + 2});
    @(posedge clock);
    #1;
    cyc++;
    if (i_rvalid) obs_i.push_back('{i_rdata, cyc});
    if (d_rvalid) obs_d.push_back('{d_rdata, cyc});
  endtask

  task automatic test_reset();
    total++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_ren, mem_wen, err_addr} !== 7'd0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_ren, mem_wen, err_addr});
    end
    total++;
    if (i_rdata !== 32'd0) begin bad++; $display("FAIL reset_i_rdata got=%h exp=0", i_rdata); end
    total++;
    if (d_rdata !== 32'd0) begin bad++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
    total++;
    if (mem_addr !== 32'd0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++;
    if (mem_din !== 32'd0) begin bad++; $display("FAIL reset_mem_din got=%h exp=0", mem_din); end
  endtask

  task automatic test_d_only();
    resp_t e, o;
    glog = "";
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd5; d_wdata = 32'hDEADBEEF;
    step();
    d_we = 1'b0;
    step();
    d_req = 1'b0;
    repeat (4) step();
    total++;
    if (glog != "DD") begin bad++; $display("FAIL d_only_grants got=%s exp=DD", glog); end
    total++;
    if (obs_d.size() != 1 || exp_d.size() != 1) begin
      bad++;
      $display("FAIL d_only_count got=%0d exp=%0d", obs_d.size(), exp_d.size());
    end
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      e = exp_d.pop_front(); o = obs_d.pop_front();
      total++;
      if (o.data !== 32'hDEADBEEF || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL d_only_read got=%h@%0d exp=%h@%0d", o.data, o.cyc, 32'hDEADBEEF, e.cyc);
      end
    end
    total++;
    if (overlap != 0) begin bad++; $display("FAIL ren_wen_overlap got=%0d exp=0", overlap); end
    exp_d.delete(); obs_d.delete();
  endtask

  task automatic test_i_stream();
    resp_t e, o;
    glog = "";
    i_req = 1'b1;
    for (int a = 0; a < 4; a++) begin
      i_addr = 32'(a);
      step();
    end
    i_req = 1'b0;
    repeat (4) step();
    total++;
    if (glog != "IIII") begin bad++; $display("FAIL i_stream_grants got=%s exp=IIII", glog); end
    total++;
    if (obs_i.size() != 4) begin bad++; $display("FAIL i_stream_count got=%0d exp=4", obs_i.size()); end
    for (int a = 0; a < 4 && exp_i.size() > 0 && obs_i.size() > 0; a++) begin
      e = exp_i.pop_front(); o = obs_i.pop_front();
      total++;
      if (o.data !== (32'hA5000000 | 32'(a)) || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL i_stream_read%0d got=%h@%0d exp=%h@%0d", a, o.data, o.cyc,
                 32'hA5000000 | 32'(a), e.cyc);
      end
    end
    exp_i.delete(); obs_i.delete();
  endtask

  task automatic test_contention();
    resp_t e, o;
    glog = "";
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd100;
    i_req = 1'b1; i_addr = 32'd200;
    repeat (10) step();
    d_req = 1'b0; i_req = 1'b0;
    repeat (4) step();
    total++;
    if (glog != "DDDDIDDDDI") begin bad++; $display("FAIL contention_grants got=%s exp=DDDDIDDDDI", glog); end
    total++;
    if (obs_d.size() != 8 || obs_i.size() != 2) begin
      bad++;
      $display("FAIL contention_count got=d%0d/i%0d exp=d8/i2", obs_d.size(), obs_i.size());
    end
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      e = exp_d.pop_front(); o = obs_d.pop_front();
      total++;
      if (o.data !== e.data || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL contention_d got=%h@%0d exp=%h@%0d", o.data, o.cyc, e.data, e.cyc);
      end
    end
    while (exp_i.size() > 0 && obs_i.size() > 0) begin
      e = exp_i.pop_front(); o = obs_i.pop_front();
      total++;
      if (o.data !== e.data || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL contention_i got=%h@%0d exp=%h@%0d", o.data, o.cyc, e.data, e.cyc);
      end
    end
    exp_i.delete(); obs_i.delete(); exp_d.delete(); obs_d.delete();
  endtask

  task automatic test_simultaneous();
    resp_t ed, od, ei, oi;
    glog = "";
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd300;
    i_req = 1'b1; i_addr = 32'd301;
    step();
    if (d_gnt) d_req = 1'b0;
    step();
    d_req = 1'b0; i_req = 1'b0;
    repeat (4) step();
    total++;
    if (glog != "DI") begin bad++; $display("FAIL simul_grants got=%s exp=DI", glog); end
    total++;
    if (obs_d.size() != 1 || obs_i.size() != 1 || exp_d.size() != 1 || exp_i.size() != 1) begin
      bad++;
      $display("FAIL simul_count got=d%0d/i%0d exp=d1/i1", obs_d.size(), obs_i.size());
    end else begin
      ed = exp_d.pop_front(); od = obs_d.pop_front();
      ei = exp_i.pop_front(); oi = obs_i.pop_front();
      total++;
      if (od.data !== (32'hA5000000 | 32'd300) || od.cyc != ed.cyc || oi.data !== (32'hA5000000 | 32'd301)
          || oi.cyc != ei.cyc || oi.cyc != od.cyc + 1) begin
        bad++;
        $display("FAIL simul_order got=d%h@%0d,i%h@%0d exp=d%h@%0d,i%h@%0d", od.data, od.cyc,
                 oi.data, oi.cyc, 32'hA5000000 | 32'd300, ed.cyc, 32'hA5000000 | 32'd301, ei.cyc);
      end
    end
    exp_i.delete(); obs_i.delete(); exp_d.delete(); obs_d.delete();
  endtask

  task automatic test_raw();
    resp_t e, o;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h0BADF00D;
    step();
    d_we = 1'b0;
    step();
    d_req = 1'b0;
    repeat (4) step();
    total++;
    if (obs_d.size() != 1) begin bad++; $display("FAIL raw_count got=%0d exp=1", obs_d.size()); end
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      e = exp_d.pop_front(); o = obs_d.pop_front();
      total++;
      if (o.data !== 32'h0BADF00D || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL raw_read got=%h@%0d exp=%h@%0d", o.data, o.cyc, 32'h0BADF00D, e.cyc);
      end
    end
    exp_d.delete(); obs_d.delete();
  endtask

  task automatic test_addr_err();
    resp_t e, o;
    total++;
    if (err_addr !== 1'b0) begin bad++; $display("FAIL err_before got=%b exp=0", err_addr); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    step();
    d_req = 1'b0; d_addr = 32'd0;
    step();
    total++;
    if (err_addr !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err_addr); end
    repeat (4) step();
    total++;
    if (err_addr !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_addr); end
    total++;
    if (obs_d.size() != 1) begin bad++; $display("FAIL err_read_count got=%0d exp=1", obs_d.size()); end
    while (exp_d.size() > 0 && obs_d.size() > 0) begin
      e = exp_d.pop_front(); o = obs_d.pop_front();
      total++;
      if (o.data !== 32'hA5000000 || o.cyc != e.cyc) begin
        bad++;
        $display("FAIL err_read_word0 got=%h@%0d exp=%h@%0d", o.data, o.cyc, 32'hA5000000, e.cyc);
      end
    end
    exp_d.delete(); obs_d.delete();
  endtask

  task automatic test_reset_mid_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'h12345678;
    @(negedge clock);
    total++;
    if (d_gnt !== 1'b1) begin bad++; $display("FAIL rmw_grant got=%b exp=1", d_gnt); end
    @(posedge clock);
    #1;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    total++;
    if (mem_wen !== 1'b1) begin bad++; $display("FAIL rmw_wen_active got=%b exp=1", mem_wen); end
    reset = 1'b1;
    #1;
    total++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_ren, mem_wen, err_addr} !== 7'd0
        || i_rdata !== 32'd0 || d_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_din !== 32'd0) begin
      bad++;
      $display("FAIL rmw_outputs got=%b/%h/%h/%h/%h exp=0",
               {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_ren, mem_wen, err_addr},
               i_rdata, d_rdata, mem_addr, mem_din);
    end
    @(negedge clock);
    #1;
    total++;
    if (mem[9] !== (32'hA5000000 | 32'd9)) begin
      bad++;
      $display("FAIL rmw_word_unchanged got=%h exp=%h", mem[9], 32'hA5000000 | 32'd9);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; overlap = 0; glog = "";
    for (int k = 0; k < 1024; k++) begin
      mem[k]     = 32'hA5000000 | 32'(k);
      ref_mem[k] = 32'hA5000000 | 32'(k);
    end
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    step();
    test_d_only();
    test_i_stream();
    test_contention();
    test_simultaneous();
    test_raw();
    test_addr_err();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
